scan_mux_reg: RTL
=================

Name: scan_mux_reg

Overview:
- Parametrised, registered N-channel, W-bit multiplexer. Successor to the 4:1 single-bit muxes.
- Manual mode: output follows an external select.
- Scan mode: an internal dwell counter steps round-robin through the channels enabled in a mask.
- Feeds time-multiplexed display and bus-sharing datapaths. Output is registered, with channel index, valid and switch-pulse status.

Parameters:
- WIDTH, 4, bit width of each channel.
- CHANNELS, 4, number of input channels (2..16).
- DWELL, 3, clock cycles spent on each channel in scan mode (1..255).
- SEL_W, derived localparam = clog2(CHANNELS), width of select/index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  CHANNELS*WIDTH  packed channels; channel k = bits [k*WIDTH +: WIDTH].
- mode  input  1  0 = manual, 1 = scan.
- sel  input  SEL_W  manual select; scan start point on mode entry.
- ch_mask  input  CHANNELS  bit k=1 enables channel k in scan.
- hold  input  1  freezes scan dwell counter and channel.
- data_out  output  WIDTH  registered selected data.
- ch_out  output  SEL_W  registered index of channel driving data_out.
- out_valid  output  1  data_out holds a legal channel.
- ch_switch  output  1  one-cycle pulse when ch_out changes value.

Behaviour:
- Reset (rst_n=0, asynchronous): data_out=0, ch_out=0, out_valid=0, ch_switch=0, dwell_cnt=0, state=S_MANUAL. Release takes effect at the next clk edge.
- Latency: 1 cycle. data_out reflects data_in sampled at the same edge that registers ch_out.
- S_MANUAL (mode=0):
  - Each edge, ch_out<=sel, data_out<=channel sel, out_valid<=1.
  - If sel>=CHANNELS: data_out<=0, out_valid<=0, ch_out unchanged.
  - ch_mask and hold are ignored.
- S_MANUAL -> scan (mode=1 sampled):
  - Target = sel if sel<CHANNELS and ch_mask[sel]=1; otherwise the next enabled channel above sel, wrapping modulo CHANNELS.
  - dwell_cnt<=0. Go to S_SCAN, or S_EMPTY if ch_mask==0.
- S_SCAN:
  - data_out<=current channel every edge (live data), out_valid<=1.
  - If hold=0: dwell_cnt increments. When dwell_cnt==DWELL-1, ch_out advances to the next enabled channel strictly after the current one (wrap) and dwell_cnt<=0.
  - If the current channel is the only enabled one, ch_out stays and no ch_switch is produced.
  - If hold=1: dwell_cnt and ch_out are frozen; data_out still resamples.
  - Current channel masked off mid-dwell: advance on the next edge regardless of dwell_cnt or hold; dwell_cnt<=0.
  - ch_mask becomes 0: go to S_EMPTY.
- S_EMPTY:
  - data_out<=0, out_valid<=0, ch_out unchanged.
  - When ch_mask becomes nonzero: select the first enabled channel at or after ch_out (wrap), dwell_cnt<=0, go to S_SCAN.
- mode=0 from S_SCAN or S_EMPTY: go to S_MANUAL on that edge, using the manual rule immediately.
- ch_switch is 1 in the cycle after any edge where registered ch_out changed, including manual sel changes. It is 0 otherwise, and 0 after reset.
- Simultaneous dwell expiry and mode=0: the mode change wins.
- Round-robin search is purely combinational: CHANNELS-wide rotate and priority encode, no multi-cycle search.

Decomposition:
- Package scan_mux_pkg holds:
  - state encoding S_MANUAL=2'd0, S_SCAN=2'd1, S_EMPTY=2'd2.
  - mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
- Sub-module rr_next_ch (combinational): inputs mask, start index, inclusive flag; outputs next index and found flag. It is instantiated twice: strict-after (scan advance) and at-or-after (mode entry and S_EMPTY exit).

Test Plan:
- Reset mid-scan: assert rst_n=0 during S_SCAN at ch_out=2 -> all outputs 0 immediately, without waiting for a clk edge; after release with mode=0, sel=1, data_in={4'hD,4'hC,4'hB,4'hA} -> data_out=4'hB, ch_out=1, out_valid=1 one cycle later.
- Manual out-of-range: CHANNELS=3, sel=3 -> out_valid=0, data_out=0; then sel=2 -> channel-2 data, out_valid=1, ch_switch pulse.
- Scan rotation: mode=1, sel=0, ch_mask=4'b1011, DWELL=3 -> ch_out sequence 0,0,0,1,1,1,3,3,3,0; ch_switch high exactly once per change.
- Hold and mask-off: hold=1 on ch 1 for 5 cycles -> ch_out stays 1 while data_out tracks input changes; clear ch_mask[1] -> ch_out=3 on the next edge even with hold=1.
- Empty mask: ch_mask=0 in scan -> out_valid=0, data_out=0; ch_mask=4'b0100 -> ch_out=2, out_valid=1 next edge.
- Entry point: sel=1, ch_mask=4'b1001, mode 0->1 -> first scan channel 3; single enabled channel -> ch_out constant and no ch_switch over 10 cycles.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// Shared FSM state type and mode constants for the scanning channel multiplexer.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_SCAN   = 2'd1,
    S_EMPTY  = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Dwell counter width; large enough for any DWELL up to 255.
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/rr_next_ch.sv
// Combinational round-robin search: finds the first channel set in mask,
// starting at (inclusive) or strictly after (exclusive) the start index.
// A start index beyond the last channel wraps to a search from channel 0.
module rr_next_ch #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  input  logic          inclusive,
  output logic [IW-1:0] next_ch,
  output logic          found
);

  localparam logic [IW:0] NUM = (IW+1)'(N);

  logic [IW:0] base;
  logic [IW:0] cand;
  logic        incl;
  logic        start_oob;

  // Walk the rotated candidate order and keep the first enabled hit.
  // In exclusive mode the final candidate wraps back onto start itself,
  // so a lone enabled channel is reported as its own successor.
  always_comb begin
    start_oob = ({1'b0, start} >= NUM);
    incl      = inclusive || start_oob;
    base      = start_oob ? '0 : {1'b0, start};
    next_ch   = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = base + (IW+1)'(off) + (IW+1)'(!incl);
      if (cand >= NUM) begin
        cand = cand - NUM;
      end
      if (!found && mask[cand[IW-1:0]]) begin
        found   = 1'b1;
        next_ch = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-channel W-bit multiplexer with manual select and a
// round-robin scan mode that dwells a fixed number of cycles per channel.
module scan_mux_reg
  import scan_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 3,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       ch_mask,
  input  logic                      hold,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          ch_out,
  output logic                      out_valid,
  output logic                      ch_switch
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]   CH_NUM     = (SEL_W+1)'(CHANNELS);

  state_t             state;
  logic [CNT_W-1:0]   dwell_cnt;
  logic [WIDTH-1:0]   chans [CHANNELS];
  logic               sel_ok;
  logic [SEL_W-1:0]   entry_start;
  logic [SEL_W-1:0]   adv_ch;
  logic               adv_found;
  logic [SEL_W-1:0]   ent_ch;
  logic               ent_found;

  // Unpack the flat input bus into per-channel words.
  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      chans[k] = data_in[k*WIDTH +: WIDTH];
    end
  end

  // Manual select legality and the start point for at-or-after searches:
  // sel when entering scan from manual, the held channel when leaving empty.
  always_comb begin
    sel_ok      = ({1'b0, sel} < CH_NUM);
    entry_start = (state == S_EMPTY) ? ch_out : sel;
  end

  rr_next_ch #(
    .N  (CHANNELS),
    .IW (SEL_W)
  ) u_adv (
    .mask      (ch_mask),
    .start     (ch_out),
    .inclusive (1'b0),
    .next_ch   (adv_ch),
    .found     (adv_found)
  );

  rr_next_ch #(
    .N  (CHANNELS),
    .IW (SEL_W)
  ) u_entry (
    .mask      (ch_mask),
    .start     (entry_start),
    .inclusive (1'b1),
    .next_ch   (ent_ch),
    .found     (ent_found)
  );

  // Mode/scan FSM with registered data, index, valid and switch pulse.
  // mode=0 is checked ahead of the state case so it overrides dwell expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_MANUAL;
      dwell_cnt <= '0;
      data_out  <= '0;
      ch_out    <= '0;
      out_valid <= 1'b0;
      ch_switch <= 1'b0;
    end else if (mode == MODE_MANUAL) begin
      state     <= S_MANUAL;
      dwell_cnt <= '0;
      if (sel_ok) begin
        ch_out    <= sel;
        data_out  <= chans[sel];
        out_valid <= 1'b1;
        ch_switch <= (sel != ch_out);
      end else begin
        data_out  <= '0;
        out_valid <= 1'b0;
        ch_switch <= 1'b0;
      end
    end else begin
      case (state)
        S_MANUAL, S_EMPTY: begin
          dwell_cnt <= '0;
          if (ent_found) begin
            state     <= S_SCAN;
            ch_out    <= ent_ch;
            data_out  <= chans[ent_ch];
            out_valid <= 1'b1;
            ch_switch <= (ent_ch != ch_out);
          end else begin
            state     <= S_EMPTY;
            data_out  <= '0;
            out_valid <= 1'b0;
            ch_switch <= 1'b0;
          end
        end
        S_SCAN: begin
          if (!adv_found) begin
            state     <= S_EMPTY;
            dwell_cnt <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            ch_switch <= 1'b0;
          end else if (!ch_mask[ch_out] ||
                       (!hold && dwell_cnt == DWELL_LAST)) begin
            // Masked-off channel advances regardless of hold or dwell.
            dwell_cnt <= '0;
            ch_out    <= adv_ch;
            data_out  <= chans[adv_ch];
            out_valid <= 1'b1;
            ch_switch <= (adv_ch != ch_out);
          end else begin
            if (!hold) begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
            data_out  <= chans[ch_out];
            out_valid <= 1'b1;
            ch_switch <= 1'b0;
          end
        end
        default: begin
          state     <= S_MANUAL;
          dwell_cnt <= '0;
          data_out  <= '0;
          out_valid <= 1'b0;
          ch_switch <= 1'b0;
        end
      endcase
    end
  end

endmodule
